// File: rtl/sample_burst_ctrl.sv
// -----------------------------------------------------------------------------
// sample_burst_ctrl
//
// Prefetches 16-bit samples from a FIFO into a one-word output buffer that
// the host drains over EBI. It raises a level interrupt once a full burst of
// T words is available, and drops it after the host has accepted T words.
//
// Ports
//   clk              system clock; all logic on its rising edge
//   rst              synchronous, active-low reset
//   fifo_dout        FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty       FIFO empty flag
//   fifo_data_count  FIFO occupancy
//   fifo_rd_en       one-cycle FIFO read pulse
//   ebi_rd_strobe    one-cycle pulse per host read of ebi_data_out
//   ebi_data_out     buffered sample word
//   out_valid        ebi_data_out holds an unread word
//   cmd_bus_*        command bus; data[30] loads T, data[31] flushes
//   irq              burst-ready interrupt (level)
//   status           {underrun, irq, out_valid, 13'b0}
// -----------------------------------------------------------------------------
module sample_burst_ctrl #(
    parameter int unsigned POSITION      = 242,
    parameter int unsigned RST_THRESHOLD = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] fifo_dout,
    input  logic        fifo_empty,
    input  logic [15:0] fifo_data_count,
    output logic        fifo_rd_en,
    input  logic        ebi_rd_strobe,
    output logic [15:0] ebi_data_out,
    output logic        out_valid,
    input  logic        cmd_bus_en,
    input  logic        cmd_bus_wr,
    input  logic [15:0] cmd_bus_addr,
    input  logic [31:0] cmd_bus_data,
    output logic        irq,
    output logic [15:0] status
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] thresh_q, thresh_d;
    logic [15:0] burst_q, burst_d;
    logic [15:0] data_q, data_d;
    logic        out_valid_q, out_valid_d;
    logic        pending_q, pending_d;
    logic        underrun_q, underrun_d;

    logic        cmd_hit;
    logic        flush;
    logic        load_t;
    logic        accept;
    logic [15:0] t_eff;
    logic [16:0] avail;
    logic        unused_cmd_bits;

    assign cmd_hit = cmd_bus_en & cmd_bus_wr & (cmd_bus_addr == 16'(POSITION));
    assign flush   = cmd_hit & cmd_bus_data[31];
    assign load_t  = cmd_hit & cmd_bus_data[30];
    assign unused_cmd_bits = ^cmd_bus_data[29:16];

    // A host read only counts when a word is actually there; a flush in the
    // same cycle discards the word instead.
    assign accept = ebi_rd_strobe & out_valid_q & ~flush;

    // A zero threshold would never arm and never finish, so it reads as one.
    assign t_eff = (thresh_q == 16'd0) ? 16'd1 : thresh_q;

    // Words reachable by the host: in the FIFO, in the buffer, and in flight.
    assign avail = {1'b0, fifo_data_count} + 17'(out_valid_q) + 17'(pending_q);

    // Refill the buffer as soon as it is empty or being read this cycle. The
    // read pulse is combinational so a strobe yields a new word two cycles
    // later; it is held off during reset so no FIFO word is silently lost.
    assign fifo_rd_en = rst & ~fifo_empty & ~pending_q & ~flush &
                        (~out_valid_q | ebi_rd_strobe);

    // NOTE: every next-state signal gets its default first, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        thresh_d    = thresh_q;
        burst_d     = burst_q;
        data_d      = data_q;
        out_valid_d = out_valid_q;
        underrun_d  = underrun_q;
        pending_d   = fifo_rd_en;

        // A new threshold only takes effect at the next arming; burst_q keeps
        // the count latched for the burst in progress.
        if (load_t) begin
            thresh_d = cmd_bus_data[15:0];
        end

        if (flush) begin
            out_valid_d = 1'b0;
            underrun_d  = 1'b0;
            state_d     = ST_IDLE;
        end else begin
            if (ebi_rd_strobe && !out_valid_q) begin
                underrun_d = 1'b1;
            end

            // A capture and an accept never conflict: the new word wins.
            if (pending_q) begin
                out_valid_d = 1'b1;
                data_d      = fifo_dout;
            end else if (accept) begin
                out_valid_d = 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (avail >= {1'b0, t_eff}) begin
                        state_d = ST_ARMED;
                        burst_d = t_eff;
                    end
                end
                ST_ARMED: begin
                    if (accept) begin
                        burst_d = burst_q - 16'd1;
                        if (burst_q == 16'd1) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the values from before this edge; reset is synchronous and
    // clears the data word too, since its reset value is visible on EBI.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            thresh_q    <= 16'(RST_THRESHOLD);
            burst_q     <= 16'd0;
            data_q      <= 16'h0000;
            out_valid_q <= 1'b0;
            pending_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            thresh_q    <= thresh_d;
            burst_q     <= burst_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            pending_q   <= pending_d;
            underrun_q  <= underrun_d;
        end
    end

    assign ebi_data_out = data_q;
    assign out_valid    = out_valid_q;
    assign irq          = (state_q == ST_ARMED);
    assign status       = {underrun_q, irq, out_valid_q, 13'b0};

endmodule

// File: doc/sample_burst_ctrl.md
SAMPLE_BURST_CTRL -- requirements
Module: sample_burst_ctrl

Interface
REQ-001 SHALL have parameter: POSITION, default 242, command-bus address that selects this block.
REQ-002 SHALL have parameter: RST_THRESHOLD, default 16, burst length loaded at reset.
REQ-003 SHALL have port: clk  in  1  system clock (sys_clk domain); all logic on its rising edge.
REQ-004 SHALL have port: rst  in  1  synchronous, active-low reset.
REQ-005 SHALL have port: fifo_dout  in  16  sample FIFO read data, valid the cycle after fifo_rd_en.
REQ-006 SHALL have port: fifo_empty  in  1  sample FIFO empty.
REQ-007 SHALL have port: fifo_data_count  in  16  sample FIFO occupancy.
REQ-008 SHALL have port: fifo_rd_en  out  1  one-cycle FIFO read pulse.
REQ-009 SHALL have port: ebi_rd_strobe  in  1  one-cycle pulse per host read of the sample data word.
REQ-010 SHALL have port: ebi_data_out  out  16  buffered sample word presented to EBI.
REQ-011 SHALL have port: out_valid  out  1  ebi_data_out holds an unread word.
REQ-012 SHALL have port: cmd_bus_en, cmd_bus_wr  in  1 each  command bus enable/write.
REQ-013 SHALL have port: cmd_bus_addr  in  16; cmd_bus_data  in  32  command bus address/data.
REQ-014 SHALL have port: irq  out  1  burst-ready interrupt to host (level).
REQ-015 SHALL have port: status  out  16  {underrun, irq, out_valid, 13'b0}, MSB first.

Function
REQ-016 SHALL keep a 16-bit threshold T; T=0 SHALL be treated as 1 everywhere.
REQ-017 Command write: cmd_bus_en & cmd_bus_wr & cmd_bus_addr==POSITION SHALL act next edge; data[30]=1 loads T<=data[15:0]; data[31]=1 flushes (out_valid<=0, state<=IDLE, underrun<=0, pending read discarded).
REQ-018 Prefetch SHALL issue fifo_rd_en when !fifo_empty & !pending & (!out_valid | (ebi_rd_strobe & out_valid)), not during a flush cycle.
REQ-019 pending SHALL be high the cycle after fifo_rd_en; that cycle ebi_data_out<=fifo_dout, out_valid<=1.
REQ-020 Read accept: ebi_rd_strobe & out_valid SHALL clear out_valid next edge unless a capture occurs the same edge (capture wins, out_valid stays 1).
REQ-021 Sustained throughput SHALL be one word per 2 cycles; strobe-to-new-word latency 2 cycles.
REQ-022 avail = fifo_data_count + out_valid + pending, 17-bit, no wrap.
REQ-023 FSM IDLE: irq=0; go ARMED when avail >= T, loading burst_cnt<=T.
REQ-024 FSM ARMED: irq=1; each accepted read decrements burst_cnt; accept at burst_cnt==1 SHALL return to IDLE (irq low next cycle); IDLE SHALL last at least one cycle before re-arming.
REQ-025 T written while ARMED SHALL NOT affect current burst_cnt; applies to next arming.
REQ-026 ebi_rd_strobe with out_valid=0 SHALL set sticky underrun, not decrement burst_cnt, leave ebi_data_out unchanged.
REQ-027 Flush and strobe same cycle: flush SHALL win; read not counted.
REQ-028 fifo_rd_en SHALL never assert when fifo_empty=1.

Reset
REQ-029 While rst=0 at an edge: fifo_rd_en=0, pending=0, out_valid=0, ebi_data_out=16'h0000, irq=0, underrun=0, state=IDLE, burst_cnt=0, T=RST_THRESHOLD.
REQ-030 Reset mid-burst SHALL abandon the burst; words already read from FIFO are lost.

Verification
REQ-031 Reset, FIFO holds 3 words (0x0001..0x0003), T=16 -> fifo_rd_en pulse, 0x0001 on ebi_data_out after 2 cycles, irq stays 0.
REQ-032 Write data=0x4000_0004 to addr 242, FIFO fed 4 words -> irq=1; 4 strobes spaced 2 cycles return words in order; irq=0 the cycle after 4th accept.
REQ-033 Strobe while out_valid=0 -> status[15]=1, irq and burst_cnt unchanged; write 0x8000_0000 -> status=0x0000.
REQ-034 Write T=0 -> behaves as T=1: irq rises with one word available, falls after single read.
REQ-035 Strobe and flush same cycle, burst_cnt=2 -> out_valid=0, state IDLE, no underrun, no word counted.
REQ-036 rst low for 1 cycle while ARMED with pending read -> all outputs at reset values next cycle, T=16.
